mem_bus_rr: RTL and testbench

MEM_BUS_RR -- requirements
Module: mem_bus_rr

---
 rtl/mem_bus_rr_pkg.sv | 24 ++
 rtl/mem_bus_rr_if.sv | 32 +++
 rtl/mem_bus_rr_arbiter.sv | 27 ++
 rtl/mem_bus_rr.sv | 146 ++++++++++++++
 tb/tb_mem_bus_rr.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_rr_pkg.sv
// Shared definitions for the round-robin memory bus: op codes, error codes
// and the controller state encoding.
package mem_bus_pkg;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WT   = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ADDR = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // A channel is requesting whenever its op code is anything but IDLE.
  function automatic logic is_req(input logic [1:0] op);
    return op != OP_IDLE;
  endfunction

endpackage

// File: rtl/mem_bus_rr_if.sv
// Bus between the cache channels and the shared memory controller.
//
// Handshake: a channel raises req_op (its "valid") with addr/wdata and holds
// them until it sees its bit of rsp_done (the one-cycle "ready"/completion
// pulse); it must drop req_op in that same cycle, otherwise the still-set op
// is taken as a fresh request. rsp_rdata/rsp_err are qualified by rsp_done.
interface mem_bus_rr_if #(
  parameter int NCH = 4,
  parameter int AW  = 8,
  parameter int DW  = 32
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*2-1:0]  req_op;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [DW-1:0]     rsp_rdata;
  logic [NCH-1:0]    rsp_done;
  logic [1:0]        rsp_err;
  logic              busy;
  logic [IW-1:0]     grant_id;

  modport master (
    output req_op, req_addr, req_wdata,
    input  rsp_rdata, rsp_done, rsp_err, busy, grant_id
  );

  modport slave (
    input  req_op, req_addr, req_wdata,
    output rsp_rdata, rsp_done, rsp_err, busy, grant_id
  );
endinterface

// File: rtl/mem_bus_rr_arbiter.sv
// Round-robin picker: first requesting channel after i_last, wrapping to 0.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         i_req,
  input  logic [$clog2(NCH)-1:0] i_last,
  output logic [$clog2(NCH)-1:0] o_grant,
  output logic                   o_valid
);
  localparam int IW = $clog2(NCH);

  logic [IW-1:0] w_idx;

  // Scan NCH positions starting one past the last grant; keep the first hit.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = IW'((int'(i_last) + i) % NCH);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end
    end
  end
endmodule

// File: rtl/mem_bus_rr.sv
// Shared memory controller: arbitrates NCH cache channels round-robin and
// serves one read/write at a time with a fixed MEMDELAY wait per access.
module mem_bus_rr
  import mem_bus_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int DEPTH    = 256,
  parameter int MEMDELAY = 5
) (
  input  logic         clk,
  input  logic         reset,
  mem_bus_rr_if.slave  bus,
  output state_t       o_dbg_state
);
  localparam int IW  = $clog2(NCH);
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t         r_state, w_state_nx;
  logic           w_exec, w_grant_go;
  logic [NCH-1:0] w_req;
  logic [IW-1:0]  w_gnt;
  logic           w_gnt_valid;
  logic [1:0]     w_sel_op;
  logic [AW-1:0]  w_sel_addr;
  logic [DW-1:0]  w_sel_wdata;
  logic           w_addr_ok;
  logic [MAW-1:0] w_idx;

  logic [IW-1:0]  r_last, r_grant;
  logic [1:0]     r_op;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [7:0]     r_cnt;
  logic [NCH-1:0] r_done;
  logic [1:0]     r_err;
  logic [DW-1:0]  r_rdata;
  logic [DW-1:0]  r_mem [DEPTH];

  // Request vector and the granted channel's op/addr/wdata slice.
  always_comb begin
    w_req       = '0;
    w_sel_op    = OP_IDLE;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      w_req[i] = is_req(bus.req_op[i*2 +: 2]);
      if (w_gnt == IW'(i)) begin
        w_sel_op    = bus.req_op[i*2 +: 2];
        w_sel_addr  = bus.req_addr[i*AW +: AW];
        w_sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_valid (w_gnt_valid)
  );

  assign w_addr_ok = 32'(r_addr) < 32'(DEPTH);
  assign w_idx     = r_addr[MAW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state: grant in IDLE, execute when the wait counter has run out.
  always_comb begin
    w_state_nx = r_state;
    w_exec     = 1'b0;
    w_grant_go = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_grant_go = 1'b1;
          w_state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 8'd0) begin
          w_exec     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Latch the winning request, count the wait, and register the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= IW'(NCH - 1);
      r_grant <= '0;
      r_op    <= OP_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_err   <= ERR_NONE;
      r_rdata <= '0;
    end else begin
      r_done <= '0;
      if (w_grant_go) begin
        r_grant <= w_gnt;
        r_last  <= w_gnt;
        r_op    <= w_sel_op;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_cnt   <= 8'(MEMDELAY);
      end else if (r_state == S_ACCESS && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_exec) begin
        r_done[r_grant] <= 1'b1;
        if (r_op == OP_ILL) begin
          r_err <= ERR_OP;
        end else if (!w_addr_ok) begin
          r_err   <= ERR_ADDR;
          r_rdata <= '0;
        end else begin
          r_err <= ERR_NONE;
          if (r_op == OP_RD) r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Memory write on the completing edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && w_exec && r_op == OP_WT && w_addr_ok)
      r_mem[w_idx] <= r_wdata;
  end

  assign bus.rsp_done  = r_done;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_rdata;
  assign bus.busy      = (r_state == S_ACCESS);
  assign bus.grant_id  = r_grant;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mem_bus_rr.sv
// Bench for mem_bus_rr: NCH=4, DEPTH=16, MEMDELAY=5, plus a MEMDELAY=0 build.
module tb_mem_bus_rr;
  import mem_bus_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int MD  = 5;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Scoreboard entry: {channel[1:0], err[1:0], rdata[31:0]}
  logic [35:0] exp_q[$];
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata;

  state_t dbg5, dbg0;

  mem_bus_rr_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();
  mem_bus_rr_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus0 ();

  mem_bus_rr #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(16), .MEMDELAY(MD)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg5)
  );

  mem_bus_rr #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(16), .MEMDELAY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .o_dbg_state(dbg0)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: returns the expected completion and updates model state.
  function automatic logic [35:0] model(input logic [1:0] ch, input logic [1:0] op,
                                        input logic [7:0] addr, input logic [31:0] wdata);
    logic [1:0] e;
    if (op == OP_ILL) begin
      e = ERR_OP;
    end else if (addr >= 8'd16) begin
      e = ERR_ADDR;
      m_rdata = 32'h0;
    end else if (op == OP_RD) begin
      e = ERR_NONE;
      m_rdata = m_mem[addr[3:0]];
    end else begin
      e = ERR_NONE;
      m_mem[addr[3:0]] = wdata;
    end
    return {ch, e, m_rdata};
  endfunction

  task automatic set_req(input int ch, input logic [1:0] op, input logic [7:0] addr,
                         input logic [31:0] wdata);
    bus.req_op[ch*2 +: 2]     = op;
    bus.req_addr[ch*8 +: 8]   = addr;
    bus.req_wdata[ch*32 +: 32] = wdata;
  endtask

  // One access on one channel; optionally disturbs its inputs mid-access.
  task automatic do_access(input int ch, input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] wdata, input bit mutate);
    int t_g, t_d, n;
    bit got;
    logic [35:0] e;
    @(negedge clk);
    set_req(ch, op, addr, wdata);
    exp_q.push_back(model(2'(ch), op, addr, wdata));
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait ch%0d: busy stayed low for %0d cycles, expected a grant", ch, n);
      void'(exp_q.pop_front());
      set_req(ch, OP_IDLE, 8'h0, 32'h0);
      return;
    end
    t_g = cyc;
    checks++;
    if (bus.grant_id !== 2'(ch)) begin
      errors++;
      $display("FAIL grant_id: got %0d expected %0d", bus.grant_id, ch);
    end
    if (mutate) set_req(ch, op, addr ^ 8'h1, ~wdata);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.rsp_done !== 4'b0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_wait ch%0d: no rsp_done within %0d cycles", ch, n);
      void'(exp_q.pop_front());
      set_req(ch, OP_IDLE, 8'h0, 32'h0);
      return;
    end
    t_d = cyc;
    set_req(ch, OP_IDLE, addr, wdata);
    e = exp_q.pop_front();
    checks++;
    if (t_d - t_g !== MD + 1) begin
      errors++;
      $display("FAIL latency ch%0d: got %0d edges expected %0d", ch, t_d - t_g, MD + 1);
    end
    checks++;
    if (bus.rsp_done !== (4'b1 << e[35:34])) begin
      errors++;
      $display("FAIL done_vec: got %b expected %b", bus.rsp_done, 4'b1 << e[35:34]);
    end
    checks++;
    if (bus.rsp_err !== e[33:32]) begin
      errors++;
      $display("FAIL rsp_err ch%0d addr %0d: got %0d expected %0d", ch, addr, bus.rsp_err, e[33:32]);
    end
    checks++;
    if (bus.rsp_rdata !== e[31:0]) begin
      errors++;
      $display("FAIL rsp_rdata ch%0d addr %0d: got %h expected %h", ch, addr, bus.rsp_rdata, e[31:0]);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_done !== 4'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b expected done=0000 busy=0", bus.rsp_done, bus.busy);
    end
  endtask

  // Collect a number of completions in order from the scoreboard.
  task automatic collect(input int count, input bit reraise0);
    int done_n, budget;
    bit raise0, used0;
    logic [35:0] e;
    done_n = 0;
    budget = 0;
    raise0 = 1'b0;
    used0  = !reraise0;
    while (done_n < count && budget < 300) begin
      @(negedge clk);
      budget++;
      if (raise0) begin
        set_req(0, OP_RD, 8'd8, 32'h0);
        exp_q.push_back(model(2'd0, OP_RD, 8'd8, 32'h0));
        raise0 = 1'b0;
      end
      if (bus.rsp_done !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra: unexpected rsp_done %b", bus.rsp_done);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_done !== (4'b1 << e[35:34])) begin
            errors++;
            $display("FAIL rr_order: got done %b expected %b", bus.rsp_done, 4'b1 << e[35:34]);
          end
          checks++;
          if (bus.rsp_rdata !== e[31:0] || bus.rsp_err !== e[33:32]) begin
            errors++;
            $display("FAIL rr_data: got %h/%0d expected %h/%0d", bus.rsp_rdata, bus.rsp_err, e[31:0], e[33:32]);
          end
        end
        for (int c = 0; c < NCH; c++)
          if (bus.rsp_done[c]) set_req(c, OP_IDLE, 8'h0, 32'h0);
        if (bus.rsp_done[0] && !used0) begin
          used0  = 1'b1;
          raise0 = 1'b1;
        end
        done_n++;
      end
    end
    checks++;
    if (done_n != count) begin
      errors++;
      $display("FAIL rr_count: got %0d completions expected %0d", done_n, count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_op = '0;  bus.req_addr = '0;  bus.req_wdata = '0;
    bus0.req_op = '0; bus0.req_addr = '0; bus0.req_wdata = '0;
    m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.rsp_done !== 4'b0) begin errors++; $display("FAIL rst_done: got %b expected 0000", bus.rsp_done); end
    checks++; if (bus.rsp_err !== ERR_NONE) begin errors++; $display("FAIL rst_err: got %0d expected 0", bus.rsp_err); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.rsp_rdata); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", bus.grant_id); end
    checks++; if (dbg5 !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg5); end
    checks++; if (bus0.busy !== 1'b0 || bus0.rsp_done !== 4'b0) begin errors++; $display("FAIL rst_dut0: busy %b done %b expected 0/0000", bus0.busy, bus0.rsp_done); end
  endtask

  task automatic test_write_read();
    do_access(0, OP_WT, 8'd3, 32'hA5, 1'b0);
    do_access(0, OP_RD, 8'd3, 32'h0, 1'b0);
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < NCH; c++) do_access(c, OP_WT, 8'(8 + c), 32'h100 + c, 1'b0);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      set_req(c, OP_RD, 8'(8 + c), 32'h0);
      exp_q.push_back(model(2'(c), OP_RD, 8'(8 + c), 32'h0));
    end
    collect(5, 1'b1);
  endtask

  task automatic test_bad_addr();
    do_access(2, OP_WT, 8'd4, 32'h44, 1'b0);
    do_access(2, OP_WT, 8'd20, 32'h1, 1'b0);
    do_access(2, OP_RD, 8'd4, 32'h0, 1'b0);
    do_access(2, OP_RD, 8'd20, 32'h0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int n;
    bit got;
    do_access(1, OP_WT, 8'd5, 32'h55, 1'b0);
    do_access(1, OP_RD, 8'd3, 32'h0, 1'b0);
    @(negedge clk);
    set_req(1, OP_WT, 8'd5, 32'hDEAD);
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL abort_grant: no grant within %0d cycles", n); end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_done !== 4'b0) begin errors++; $display("FAIL abort_early_done: got %b expected 0000", bus.rsp_done); end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(1, OP_IDLE, 8'h0, 32'h0);
    m_rdata = 32'h0;
    checks++; if (bus.busy !== 1'b0 || dbg5 !== S_IDLE) begin errors++; $display("FAIL abort_state: busy %b state %0d expected 0/0", bus.busy, dbg5); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", bus.rsp_rdata); end
    checks++; if (bus.grant_id !== 2'd0 || bus.rsp_err !== ERR_NONE) begin errors++; $display("FAIL abort_outs: grant %0d err %0d expected 0/0", bus.grant_id, bus.rsp_err); end
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_done !== 4'b0) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_done: saw %0d done pulses expected 0", n); end
    // After reset channel 0 must win over channel 2 again.
    set_req(2, OP_RD, 8'd4, 32'h0);
    set_req(0, OP_RD, 8'd3, 32'h0);
    exp_q.push_back(model(2'd0, OP_RD, 8'd3, 32'h0));
    exp_q.push_back(model(2'd2, OP_RD, 8'd4, 32'h0));
    collect(2, 1'b0);
    do_access(1, OP_RD, 8'd5, 32'h0, 1'b0);
  endtask

  task automatic test_illegal_and_mid_change();
    do_access(3, OP_ILL, 8'd2, 32'h99, 1'b0);
    do_access(1, OP_WT, 8'd7, 32'h70, 1'b0);
    do_access(1, OP_WT, 8'd6, 32'h66, 1'b1);
    do_access(1, OP_RD, 8'd6, 32'h0, 1'b0);
    do_access(1, OP_RD, 8'd7, 32'h0, 1'b0);
  endtask

  task automatic access0(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
    int t_g, n;
    bit got;
    @(negedge clk);
    bus0.req_op[1:0] = op; bus0.req_addr[7:0] = addr; bus0.req_wdata[31:0] = wdata;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bus0.busy === 1'b1) got = 1'b1;
    end
    t_g = cyc;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (bus0.rsp_done !== 4'b0) got = 1'b1;
    end
    bus0.req_op[1:0] = OP_IDLE;
    checks++;
    if (!got || cyc - t_g != 1) begin
      errors++;
      $display("FAIL md0_latency: got %0d edges (done seen %b) expected 1", cyc - t_g, got);
    end
    checks++;
    if (bus0.rsp_done !== 4'b0001 || bus0.rsp_err !== ERR_NONE || bus0.rsp_rdata !== exp_rd) begin
      errors++;
      $display("FAIL md0_resp: done %b err %0d rdata %h expected 0001/0/%h",
               bus0.rsp_done, bus0.rsp_err, bus0.rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_zero_delay();
    access0(OP_WT, 8'd0, 32'h33, 32'h0);
    access0(OP_RD, 8'd0, 32'h0, 32'h33);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_bad_addr();
    test_reset_abort();
    test_illegal_and_mid_change();
    test_zero_delay();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
